// File: rtl/gpio_rf_switch_seq_pkg.sv
// Shared definitions for the idle-state RF switch pattern sequencer: register
// offsets and state encodings, also used by the software readback decoder.
package gpio_rf_switch_seq_pkg;

   localparam logic [7:0] REG_CTRL  = 8'd0;
   localparam logic [7:0] REG_DWELL = 8'd1;
   localparam logic [7:0] REG_GUARD = 8'd2;
   localparam logic [7:0] REG_TABLE = 8'd3;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DWELL = 2'd1,
      ST_GUARD = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   function automatic logic [7:0] reg_addr(input int base, input logic [7:0] off);
      return 8'(base) + off;
   endfunction

endpackage

// File: rtl/gpio_rf_switch_seq_pattern_ram.sv
// DEPTH x WIDTH flop pattern table: one write port, two combinational read
// ports (current and next entry), cleared asynchronously with the block.
module gpio_seq_pattern_ram #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 10,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0] raddr_a_i,
   output logic [WIDTH-1:0] rdata_a_o,
   input  logic [IDX_W-1:0] raddr_b_i,
   output logic [WIDTH-1:0] rdata_b_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the table is built from flops and cleared on reset so a stale
   // pattern can never reach the RF switches before software reloads it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/gpio_rf_switch_seq.sv
// Idle-state RF switch pattern sequencer: steps a programmable GPIO pattern
// table with dwell and break-before-make guard intervals, frozen while rx|tx.
module gpio_rf_switch_seq
   import gpio_rf_switch_seq_pkg::*;
#(
   parameter  int BASE    = 0,
   parameter  int WIDTH   = 10,
   parameter  int DEPTH   = 8,
   parameter  int DWELL_W = 16,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic             rx,
   input  logic             tx,
   output logic [WIDTH-1:0] seq_out,
   output logic [IDX_W-1:0] seq_idx,
   output logic             seq_active,
   output logic             step_stb,
   output logic [31:0]      rb_status
);

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   logic               enable_q;
   logic [IDX_W-1:0]   last_idx_q;
   logic [DWELL_W-1:0] dwell_len_q;
   logic [DWELL_W-1:0] guard_len_q;
   logic               rx_q, tx_q;
   logic               run;
   state_e             state_q, saved_q;
   logic [IDX_W-1:0]   idx_q, nxt_idx;
   logic [DWELL_W-1:0] cnt_q;
   logic [WIDTH-1:0]   seq_out_q;
   logic               step_q;
   logic               tbl_we;
   logic [WIDTH-1:0]   pat_cur, pat_nxt;
   logic               unused_set_data;

   assign unused_set_data = ^set_data;

   // NOTE: every register below uses non-blocking assignments so all flops
   // sample the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q    <= 1'b0;
         last_idx_q  <= '0;
         dwell_len_q <= '0;
         guard_len_q <= '0;
         rx_q        <= 1'b0;
         tx_q        <= 1'b0;
      end else begin
         rx_q <= rx;
         tx_q <= tx;
         if (set_stb && set_addr == reg_addr(BASE, REG_CTRL)) begin
            enable_q   <= set_data[0];
            last_idx_q <= set_data[IDX_W:1];
         end
         if (set_stb && set_addr == reg_addr(BASE, REG_DWELL)) dwell_len_q <= set_data[DWELL_W-1:0];
         if (set_stb && set_addr == reg_addr(BASE, REG_GUARD)) guard_len_q <= set_data[DWELL_W-1:0];
      end
   end

   assign run     = rx_q | tx_q;
   assign tbl_we  = set_stb && set_addr == reg_addr(BASE, REG_TABLE);
   assign nxt_idx = (idx_q >= last_idx_q) ? '0 : idx_q + IDX_ONE;

   gpio_seq_pattern_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
      .clk       (clk),
      .reset     (reset),
      .we_i      (tbl_we),
      .waddr_i   (set_data[16 +: IDX_W]),
      .wdata_i   (set_data[WIDTH-1:0]),
      .raddr_a_i (idx_q),
      .rdata_a_o (pat_cur),
      .raddr_b_i (nxt_idx),
      .rdata_b_o (pat_nxt)
   );

   // seq_out is computed from the next state so it changes on the same edge
   // as state/idx; in HOLD it simply keeps its last value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_OFF;
         saved_q   <= ST_OFF;
         idx_q     <= '0;
         cnt_q     <= '0;
         seq_out_q <= '0;
         step_q    <= 1'b0;
      end else begin
         step_q <= 1'b0;
         if (!enable_q) begin
            state_q   <= ST_OFF;
            idx_q     <= '0;
            cnt_q     <= '0;
            seq_out_q <= '0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  if (!run) begin
                     state_q   <= ST_DWELL;
                     idx_q     <= '0;
                     cnt_q     <= dwell_len_q;
                     seq_out_q <= pat_cur;
                  end
               end
               ST_HOLD: begin
                  if (!run) state_q <= saved_q;
               end
               default: begin
                  if (run) begin
                     saved_q <= state_q;
                     state_q <= ST_HOLD;
                  end else if (cnt_q != '0) begin
                     cnt_q     <= cnt_q - 1'b1;
                     seq_out_q <= (state_q == ST_GUARD) ? (pat_cur & pat_nxt) : pat_cur;
                  end else if (state_q == ST_DWELL && guard_len_q != '0) begin
                     state_q   <= ST_GUARD;
                     cnt_q     <= guard_len_q - 1'b1;
                     seq_out_q <= pat_cur & pat_nxt;
                  end else begin
                     state_q   <= ST_DWELL;
                     idx_q     <= nxt_idx;
                     cnt_q     <= dwell_len_q;
                     seq_out_q <= pat_nxt;
                     step_q    <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign seq_out    = seq_out_q;
   assign seq_idx    = idx_q;
   assign seq_active = (state_q != ST_OFF);
   assign step_stb   = step_q;
   assign rb_status  = {12'b0, state_q, 4'(idx_q), 2'b0, 12'(seq_out_q)};

endmodule
